// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - ifu_fetch bundle: imem read channel, decode handshake, next-PC return
interface ifu_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Instruction memory read channel
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;
   // Decode-side handshake
   logic [DATA_W-1:0] inst;
   logic [ADDR_W-1:0] pc;
   logic              inst_fault;
   logic              inst_valid;
   logic              inst_ready;
   // Next PC from execute/write-back
   logic [ADDR_W-1:0] npc;
   logic              npc_valid;
   // Completed fetch counter
   logic [31:0]       fetch_cnt;

   modport master (
      output araddr, arvalid, rready,
      input  arready, rdata, rresp, rvalid,
      output inst, pc, inst_fault, inst_valid,
      input  inst_ready,
      input  npc, npc_valid,
      output fetch_cnt
   );

   modport slave (
      input  araddr, arvalid, rready,
      output arready, rdata, rresp, rvalid,
      input  inst, pc, inst_fault, inst_valid,
      output inst_ready,
      output npc, npc_valid,
      input  fetch_cnt
   );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-in-flight instruction fetch unit; optional IFU_MISALIGN_CHECK_EN
module ifu_fetch #(
   parameter int              ADDR_W   = 32,
   parameter int              DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h80000000
) (
   input  logic         clk,
   input  logic         rst,
   ifu_fetch_if.master  bus
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] REQ     = 3'd1;
   localparam logic [2:0] WAIT    = 3'd2;
   localparam logic [2:0] HOLD    = 3'd3;
   localparam logic [2:0] WAIT_PC = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] inst_q, inst_d;
   logic              fault_q, fault_d;
   logic [31:0]       cnt_q, cnt_d;

   // Next-state decode: one instruction in flight, advance only on the handshake of the current phase
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      fault_d = fault_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
`ifdef IFU_MISALIGN_CHECK_EN
            if (RESET_PC[1:0] != 2'b00) begin
               inst_d  = '0;
               fault_d = 1'b1;
               state_d = HOLD;
            end else begin
               state_d = REQ;
            end
`else
            state_d = REQ;
`endif
         end
         REQ: begin
            if (bus.arready) state_d = WAIT;
         end
         WAIT: begin
            if (bus.rvalid) begin
               inst_d  = bus.rdata;
               fault_d = (bus.rresp != 2'b00);
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (bus.inst_ready) begin
               cnt_d   = cnt_q + 32'd1;
               state_d = WAIT_PC;
            end
         end
         WAIT_PC: begin
            if (bus.npc_valid) begin
               pc_d = bus.npc;
`ifdef IFU_MISALIGN_CHECK_EN
               // A misaligned target never reaches memory; it is reported as a faulting fetch
               if (bus.npc[1:0] != 2'b00) begin
                  inst_d  = '0;
                  fault_d = 1'b1;
                  state_d = HOLD;
               end else begin
                  state_d = REQ;
               end
`else
               state_d = REQ;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset wins over any transaction in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         fault_q <= 1'b0;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are decoded from registered state only
   assign bus.araddr     = pc_q;
   assign bus.arvalid    = (state_q == REQ);
   assign bus.rready     = (state_q == WAIT);
   assign bus.inst       = inst_q;
   assign bus.pc         = pc_q;
   assign bus.inst_fault = fault_q;
   assign bus.inst_valid = (state_q == HOLD);
   assign bus.fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
module tb_ifu_fetch;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   ifu_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   ifu_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h80000000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Advance one clock and land on the following falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      rst = 1'b1;
      bus.arready = 1'b0;
      bus.rdata = '0;
      bus.rresp = 2'b00;
      bus.rvalid = 1'b0;
      bus.inst_ready = 1'b0;
      bus.npc = '0;
      bus.npc_valid = 1'b0;
      tick();
      tick();

      check("rst_arvalid", 32'(bus.arvalid), 32'd0);
      check("rst_rready", 32'(bus.rready), 32'd0);
      check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_pc", bus.pc, 32'h80000000);
      check("rst_inst", bus.inst, 32'd0);
      check("rst_inst_fault", 32'(bus.inst_fault), 32'd0);
      check("rst_fetch_cnt", bus.fetch_cnt, 32'd0);

      // Fast path: memory always ready
      rst = 1'b0;
      bus.arready = 1'b1;
      bus.rvalid = 1'b1;
      bus.rdata = 32'h00000013;
      bus.rresp = 2'b00;
      bus.inst_ready = 1'b1;
      check("idle_arvalid", 32'(bus.arvalid), 32'd0);
      tick();
      check("req_arvalid", 32'(bus.arvalid), 32'd1);
      check("req_araddr", bus.araddr, 32'h80000000);
      tick();
      check("wait_rready", 32'(bus.rready), 32'd1);
      check("wait_inst_valid", 32'(bus.inst_valid), 32'd0);
      tick();
      check("f1_inst_valid", 32'(bus.inst_valid), 32'd1);
      check("f1_inst", bus.inst, 32'h00000013);
      check("f1_pc", bus.pc, 32'h80000000);
      check("f1_fault", 32'(bus.inst_fault), 32'd0);
      tick();
      check("f1_done_valid", 32'(bus.inst_valid), 32'd0);
      check("f1_fetch_cnt", bus.fetch_cnt, 32'd1);
      check("waitpc_arvalid", 32'(bus.arvalid), 32'd0);

      // Address stall: arready low for 5 cycles
      bus.arready = 1'b0;
      bus.inst_ready = 1'b0;
      bus.npc = 32'h80000000;
      bus.npc_valid = 1'b1;
      tick();
      bus.npc_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_arvalid", 32'(bus.arvalid), 32'd1);
         check("stall_araddr", bus.araddr, 32'h80000000);
         tick();
      end
      bus.arready = 1'b1;
      tick();
      check("stall_wait_valid", 32'(bus.inst_valid), 32'd0);
      tick();
      check("stall_inst_valid", 32'(bus.inst_valid), 32'd1);

      // Decoder back-pressure in HOLD, with an ignored npc strobe
      bus.rdata = 32'hDEADBEEF;
      bus.npc = 32'h80000040;
      bus.npc_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.npc_valid = 1'b0;
         check("hold_valid", 32'(bus.inst_valid), 32'd1);
         check("hold_inst", bus.inst, 32'h00000013);
         check("hold_pc", bus.pc, 32'h80000000);
         check("hold_cnt", bus.fetch_cnt, 32'd1);
         check("hold_arvalid", 32'(bus.arvalid), 32'd0);
      end
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
      check("hold_done_cnt", bus.fetch_cnt, 32'd2);
      check("hold_done_valid", 32'(bus.inst_valid), 32'd0);
      tick();
      check("npc_ignored_arvalid", 32'(bus.arvalid), 32'd0);

      // Redirect and faulting response
      bus.npc = 32'h80000010;
      bus.npc_valid = 1'b1;
      bus.rdata = 32'h0BADF00D;
      bus.rresp = 2'b10;
      tick();
      bus.npc_valid = 1'b0;
      check("npc_arvalid", 32'(bus.arvalid), 32'd1);
      check("npc_araddr", bus.araddr, 32'h80000010);
      tick();
      tick();
      check("fault_valid", 32'(bus.inst_valid), 32'd1);
      check("fault_flag", 32'(bus.inst_fault), 32'd1);
      check("fault_pc", bus.pc, 32'h80000010);
      check("fault_inst", bus.inst, 32'h0BADF00D);
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
      check("fault_cnt", bus.fetch_cnt, 32'd3);

      // Reset while waiting on read data
      bus.rresp = 2'b00;
      bus.rvalid = 1'b0;
      bus.npc = 32'h80000020;
      bus.npc_valid = 1'b1;
      tick();
      bus.npc_valid = 1'b0;
      tick();
      check("mid_rready", 32'(bus.rready), 32'd1);
      bus.rvalid = 1'b1;
      rst = 1'b1;
      tick();
      check("mid_rst_arvalid", 32'(bus.arvalid), 32'd0);
      check("mid_rst_rready", 32'(bus.rready), 32'd0);
      check("mid_rst_valid", 32'(bus.inst_valid), 32'd0);
      check("mid_rst_pc", bus.pc, 32'h80000000);
      check("mid_rst_cnt", bus.fetch_cnt, 32'd0);

      // Misaligned next PC
      rst = 1'b0;
      bus.rdata = 32'h00000013;
      bus.inst_ready = 1'b1;
      tick();
      tick();
      tick();
      tick();
      bus.inst_ready = 1'b0;
      check("mis_pre_cnt", bus.fetch_cnt, 32'd1);
      bus.npc = 32'h80000006;
      bus.npc_valid = 1'b1;
      tick();
      bus.npc_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      check("mis_arvalid", 32'(bus.arvalid), 32'd0);
      check("mis_valid", 32'(bus.inst_valid), 32'd1);
      check("mis_inst", bus.inst, 32'd0);
      check("mis_fault", 32'(bus.inst_fault), 32'd1);
      check("mis_pc", bus.pc, 32'h80000006);
`else
      check("mis_arvalid", 32'(bus.arvalid), 32'd1);
      check("mis_araddr", bus.araddr, 32'h80000006);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
